// File: rtl/cache_wb_engine_pkg.sv
// Shared cache definitions used by the write-back engine: line geometry and
// the engine's state encoding.
package cache_wb_engine_pkg;

    // Word index width; a line holds 2**CNT_W words.
    localparam int unsigned CNT_W = 4;

    // Byte-offset bits inside one 32-bit word.
    localparam int unsigned WORD_OFF = 2;

    // Write-back engine states.
    typedef enum logic [2:0] {
        StIdle = 3'd0,
        StRd   = 3'd1,
        StLat  = 3'd2,
        StSend = 3'd3,
        StDone = 3'd4
    } wb_state_e;

endpackage

// File: rtl/cache_wb_engine_if.sv
// Bundle of the write-back engine's controller, data-array and memory-write
// signals. The engine uses the master view; its environment uses the slave view.
interface cache_wb_engine_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CNT_W  = cache_wb_engine_pkg::CNT_W
);

    // Cache controller side.
    logic              wb_start;
    logic [ADDR_W-1:0] wb_addr;
    logic              wb_busy;
    logic              wb_done;

    // Data-array read port.
    logic              arr_rd_en;
    logic [CNT_W-1:0]  arr_rd_idx;
    logic [DATA_W-1:0] arr_rd_data;

    // Memory write port.
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ack;

    modport master (
        input  wb_start,
        input  wb_addr,
        output wb_busy,
        output wb_done,
        output arr_rd_en,
        output arr_rd_idx,
        input  arr_rd_data,
        output mem_req,
        output mem_addr,
        output mem_wdata,
        input  mem_ack
    );

    modport slave (
        output wb_start,
        output wb_addr,
        input  wb_busy,
        input  wb_done,
        input  arr_rd_en,
        input  arr_rd_idx,
        output arr_rd_data,
        input  mem_req,
        input  mem_addr,
        input  mem_wdata,
        output mem_ack
    );

endinterface

// File: rtl/cache_wb_engine_cnt.sv
// Cache word counter with synchronous clear and a hold enable.
// Wraps modulo 2**W; clear has priority over the enable.
module cache_wb_engine_cnt
    import cache_wb_engine_pkg::*;
#(
    parameter int unsigned W = CNT_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] cnt
);

    // Word index: cleared on a new line, advanced only when enabled.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/cache_wb_engine.sv
// Write-back engine: streams a dirty line out of the data array into memory,
// one word at a time (array read, read latency, memory write with req/ack).
// Outputs come only from registers, so nothing on the bus is combinationally
// dependent on an input.
module cache_wb_engine #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CNT_W  = cache_wb_engine_pkg::CNT_W
) (
    input  logic              clk,
    input  logic              rst,
    cache_wb_engine_if.master bus
);

    import cache_wb_engine_pkg::*;

    // Width of the line-aligned part of the byte address.
    localparam int unsigned LB_W = ADDR_W - CNT_W - WORD_OFF;
    localparam logic [CNT_W-1:0] LAST_IDX = '1;

    wb_state_e         state_q;
    logic [LB_W-1:0]   line_base_q;
    logic [DATA_W-1:0] data_q;
    logic [CNT_W-1:0]  cnt;
    logic              busy_q;
    logic              done_q;
    logic              rd_en_q;
    logic              req_q;

    logic              start_acc;
    logic              word_ack;
    logic              unused_addr_bits;

    // A start is only taken in IDLE; an ack only counts while a word is offered.
    assign start_acc = (state_q == StIdle) && bus.wb_start;
    assign word_ack  = (state_q == StSend) && bus.mem_ack;

    // The offset bits of the line address carry no information.
    assign unused_addr_bits = ^bus.wb_addr[CNT_W+WORD_OFF-1:0];

    cache_wb_engine_cnt #(
        .W (CNT_W)
    ) u_cnt (
        .clk (clk),
        .rst (rst),
        .clr (start_acc),
        .en  (word_ack),
        .cnt (cnt)
    );

    // Sequencer: RD -> LAT -> SEND per word, DONE after the last ack.
    // Strobes are set on the transition into the state that owns them.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StIdle;
            line_base_q <= '0;
            data_q      <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            rd_en_q     <= 1'b0;
            req_q       <= 1'b0;
        end else begin
            done_q  <= 1'b0;
            rd_en_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (bus.wb_start) begin
                        state_q     <= StRd;
                        line_base_q <= bus.wb_addr[ADDR_W-1:CNT_W+WORD_OFF];
                        busy_q      <= 1'b1;
                        rd_en_q     <= 1'b1;
                    end
                end
                StRd: begin
                    state_q <= StLat;
                end
                StLat: begin
                    state_q <= StSend;
                    data_q  <= bus.arr_rd_data;
                    req_q   <= 1'b1;
                end
                StSend: begin
                    if (bus.mem_ack) begin
                        req_q <= 1'b0;
                        if (cnt == LAST_IDX) begin
                            state_q <= StDone;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= StRd;
                            rd_en_q <= 1'b1;
                        end
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                    req_q   <= 1'b0;
                end
            endcase
        end
    end

    // Output drive straight from registers.
    always_comb begin
        bus.wb_busy    = busy_q;
        bus.wb_done    = done_q;
        bus.arr_rd_en  = rd_en_q;
        bus.arr_rd_idx = cnt;
        bus.mem_req    = req_q;
        bus.mem_addr   = {line_base_q, cnt, {WORD_OFF{1'b0}}};
        bus.mem_wdata  = data_q;
    end

    // Only one word in flight: never read the array while a write is pending.
    assert property (@(posedge clk) disable iff (!rst) !(req_q && rd_en_q));

    // A pending write keeps its payload until it is accepted.
    assert property (@(posedge clk) disable iff (!rst)
        (req_q && !bus.mem_ack) |=> (req_q && $stable(data_q) && $stable(cnt)));

    // Any bus activity implies the engine reports busy.
    assert property (@(posedge clk) disable iff (!rst)
        (req_q || rd_en_q || done_q) |-> busy_q);

endmodule
